// File: rtl/decode_stage_if.sv
// Fetch-side, writeback-side and execute-side signals of the ID stage.
// The stage itself uses the slave modport; the driver of the stage uses master.
interface decode_stage_if #(parameter int DATA_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic              flush;
    logic              ex_memRead;
    logic [4:0]        ex_rt;
    logic              regWrite;
    logic [4:0]        writeReg;
    logic [DATA_W-1:0] writeData;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        opCode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [DATA_W-1:0] signExtendedImmidiate;
    logic [DATA_W-1:0] zeroExtendedImmidiate;

    modport slave (
        input  in_valid, instruction, flush, ex_memRead, ex_rt,
               regWrite, writeReg, writeData, out_ready,
        output in_ready, out_valid, opCode, funct, shamt, rs, rt, rd,
               readData1, readData2, signExtendedImmidiate, zeroExtendedImmidiate
    );

    modport master (
        output in_valid, instruction, flush, ex_memRead, ex_rt,
               regWrite, writeReg, writeData, out_ready,
        input  in_ready, out_valid, opCode, funct, shamt, rs, rt, rd,
               readData1, readData2, signExtendedImmidiate, zeroExtendedImmidiate
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS instruction decode stage: field split, register file with writeback bypass,
// immediate extension, load-use stall, flush and a single valid/ready output slot.
module decode_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_CNT  = 32,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);
    localparam int AW = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

    typedef struct packed {
        logic [5:0]        opCode;
        logic [5:0]        funct;
        logic [4:0]        shamt;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] simm;
        logic [DATA_W-1:0] zimm;
    } dec_t;

    logic [DATA_W-1:0] regs [REG_CNT];
    logic [4:0]        rs_in, rt_in;
    logic              wr_en, hazard, slot_free, accept;
    logic [DATA_W-1:0] rd1, rd2;
    dec_t              dec_d, dec_q;
    logic              out_valid_q;

    assign rs_in = bus.instruction[25:21];
    assign rt_in = bus.instruction[20:16];

    assign wr_en = bus.regWrite && (32'(bus.writeReg) < 32'(REG_CNT)) &&
                   !(ZERO_REG != 0 && bus.writeReg == 5'd0);

    // Out-of-range and hardwired-zero indices read 0; a same-cycle write wins over the array.
    always_comb begin
        rd1 = '0;
        if (32'(rs_in) < 32'(REG_CNT) && !(ZERO_REG != 0 && rs_in == 5'd0))
            rd1 = (wr_en && bus.writeReg == rs_in) ? bus.writeData : regs[rs_in[AW-1:0]];
    end

    always_comb begin
        rd2 = '0;
        if (32'(rt_in) < 32'(REG_CNT) && !(ZERO_REG != 0 && rt_in == 5'd0))
            rd2 = (wr_en && bus.writeReg == rt_in) ? bus.writeData : regs[rt_in[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[bus.writeReg[AW-1:0]] <= bus.writeData;
        end
    end

    assign hazard    = bus.in_valid && bus.ex_memRead && (bus.ex_rt != 5'd0) &&
                       (bus.ex_rt == rs_in || bus.ex_rt == rt_in);
    assign slot_free = !out_valid_q || bus.out_ready;
    assign accept    = bus.in_valid && bus.in_ready;

    always_comb begin
        dec_d        = '0;
        dec_d.opCode = bus.instruction[31:26];
        dec_d.funct  = bus.instruction[5:0];
        dec_d.shamt  = bus.instruction[10:6];
        dec_d.rs     = rs_in;
        dec_d.rt     = rt_in;
        dec_d.rd     = bus.instruction[15:11];
        dec_d.rd1    = rd1;
        dec_d.rd2    = rd2;
        dec_d.simm   = DATA_W'($signed(bus.instruction[15:0]));
        dec_d.zimm   = DATA_W'(bus.instruction[15:0]);
    end

    // Flush beats accept; fields only move on accept so a held slot stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            dec_q       <= dec_d;
        end else if (slot_free) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready              = rst_n && slot_free && !hazard && !bus.flush;
    assign bus.out_valid             = out_valid_q;
    assign bus.opCode                = dec_q.opCode;
    assign bus.funct                 = dec_q.funct;
    assign bus.shamt                 = dec_q.shamt;
    assign bus.rs                    = dec_q.rs;
    assign bus.rt                    = dec_q.rt;
    assign bus.rd                    = dec_q.rd;
    assign bus.readData1             = dec_q.rd1;
    assign bus.readData2             = dec_q.rd2;
    assign bus.signExtendedImmidiate = dec_q.simm;
    assign bus.zeroExtendedImmidiate = dec_q.zimm;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default config plus ZERO_REG=0 and REG_CNT=16 variants.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(32)) i0 ();
    decode_stage_if #(.DATA_W(32)) i1 ();
    decode_stage_if #(.DATA_W(32)) i2 ();

    decode_stage #(.DATA_W(32), .REG_CNT(32), .ZERO_REG(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    decode_stage #(.DATA_W(32), .REG_CNT(32), .ZERO_REG(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    decode_stage #(.DATA_W(32), .REG_CNT(16), .ZERO_REG(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        i0.in_valid = 0; i0.instruction = '0; i0.flush = 0; i0.ex_memRead = 0; i0.ex_rt = '0;
        i0.regWrite = 0; i0.writeReg = '0; i0.writeData = '0; i0.out_ready = 1;
        i1.in_valid = 0; i1.instruction = '0; i1.flush = 0; i1.ex_memRead = 0; i1.ex_rt = '0;
        i1.regWrite = 0; i1.writeReg = '0; i1.writeData = '0; i1.out_ready = 1;
        i2.in_valid = 0; i2.instruction = '0; i2.flush = 0; i2.ex_memRead = 0; i2.ex_rt = '0;
        i2.regWrite = 0; i2.writeReg = '0; i2.writeData = '0; i2.out_ready = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_all();
        i0.in_valid = 1; i0.instruction = 32'h00A0_0000;
        repeat (3) step();
        checks++; if (i0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", i0.out_valid); end
        checks++; if (i0.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", i0.in_ready); end
        checks++; if (i0.readData1 !== 32'h0) begin errors++; $display("FAIL reset_readData1 got %h exp 0", i0.readData1); end
        rst_n = 1;
        step();
        // read r5 after reset
        checks++; if (i0.out_valid !== 1'b1 || i0.readData1 !== 32'h0 || i0.rs !== 5'd5) begin
            errors++; $display("FAIL reset_read_r5 got v=%0b d=%h rs=%0d exp v=1 d=0 rs=5", i0.out_valid, i0.readData1, i0.rs);
        end
        i0.in_valid = 0;
        step();
        checks++; if (i0.out_valid !== 1'b0) begin errors++; $display("FAIL bubble_after_read got %0b exp 0", i0.out_valid); end
    endtask

    task automatic test_bypass();
        i0.in_valid = 1; i0.instruction = 32'h0060_0000;
        i0.regWrite = 1; i0.writeReg = 5'd3; i0.writeData = 32'hDEAD_BEEF;
        #1;
        checks++; if (i0.in_ready !== 1'b1) begin errors++; $display("FAIL bypass_in_ready got %0b exp 1", i0.in_ready); end
        step();
        i0.in_valid = 0; i0.regWrite = 0;
        checks++; if (i0.out_valid !== 1'b1 || i0.readData1 !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL bypass_data got v=%0b d=%h exp v=1 d=deadbeef", i0.out_valid, i0.readData1);
        end
        // stored value visible without bypass
        i0.in_valid = 1; i0.instruction = 32'h0060_0000;
        step();
        i0.in_valid = 0;
        checks++; if (i0.readData1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL regfile_r3 got %h exp deadbeef", i0.readData1); end
    endtask

    task automatic test_immediates();
        i0.in_valid = 1; i0.instruction = 32'h2008_FFFC;
        step();
        i0.in_valid = 0;
        checks++; if (i0.signExtendedImmidiate !== 32'hFFFF_FFFC) begin errors++; $display("FAIL sign_imm got %h exp fffffffc", i0.signExtendedImmidiate); end
        checks++; if (i0.zeroExtendedImmidiate !== 32'h0000_FFFC) begin errors++; $display("FAIL zero_imm got %h exp 0000fffc", i0.zeroExtendedImmidiate); end
        checks++; if (i0.opCode !== 6'h08 || i0.rt !== 5'd8 || i0.rs !== 5'd0) begin
            errors++; $display("FAIL imm_fields got op=%h rt=%0d rs=%0d exp op=08 rt=8 rs=0", i0.opCode, i0.rt, i0.rs);
        end
        // positive immediate: both extensions agree
        i0.in_valid = 1; i0.instruction = 32'h2008_7FFF;
        step();
        i0.in_valid = 0;
        checks++; if (i0.signExtendedImmidiate !== 32'h0000_7FFF) begin errors++; $display("FAIL sign_imm_pos got %h exp 00007fff", i0.signExtendedImmidiate); end
    endtask

    task automatic test_load_use();
        i0.ex_memRead = 1; i0.ex_rt = 5'd8;
        i0.in_valid = 1; i0.instruction = 32'h0109_5020;
        #1;
        checks++; if (i0.in_ready !== 1'b0) begin errors++; $display("FAIL hazard_in_ready got %0b exp 0", i0.in_ready); end
        step();
        checks++; if (i0.out_valid !== 1'b0) begin errors++; $display("FAIL hazard_bubble got %0b exp 0", i0.out_valid); end
        step();
        checks++; if (i0.out_valid !== 1'b0 || i0.in_ready !== 1'b0) begin
            errors++; $display("FAIL hazard_persist got v=%0b rdy=%0b exp v=0 rdy=0", i0.out_valid, i0.in_ready);
        end
        i0.ex_memRead = 0;
        #1;
        checks++; if (i0.in_ready !== 1'b1) begin errors++; $display("FAIL hazard_release got %0b exp 1", i0.in_ready); end
        step();
        i0.in_valid = 0;
        checks++; if (i0.out_valid !== 1'b1 || i0.rd !== 5'd10 || i0.funct !== 6'h20 || i0.rs !== 5'd8 || i0.rt !== 5'd9) begin
            errors++; $display("FAIL hazard_accept got v=%0b rd=%0d fn=%h rs=%0d rt=%0d exp v=1 rd=10 fn=20 rs=8 rt=9",
                               i0.out_valid, i0.rd, i0.funct, i0.rs, i0.rt);
        end
        // load into r0 never stalls
        i0.ex_memRead = 1; i0.ex_rt = 5'd0; i0.in_valid = 1; i0.instruction = 32'h0000_0020;
        #1;
        checks++; if (i0.in_ready !== 1'b1) begin errors++; $display("FAIL hazard_r0 got %0b exp 1", i0.in_ready); end
        step();
        i0.in_valid = 0; i0.ex_memRead = 0;
        step();
    endtask

    task automatic test_backpressure_flush();
        i0.out_ready = 0;
        i0.in_valid = 1; i0.instruction = 32'h3C0A_1234;
        step();
        i0.instruction = 32'h2008_0005;
        for (int c = 0; c < 3; c++) begin
            checks++; if (i0.out_valid !== 1'b1 || i0.in_ready !== 1'b0 || i0.zeroExtendedImmidiate !== 32'h1234 || i0.opCode !== 6'h0F) begin
                errors++; $display("FAIL hold_%0d got v=%0b rdy=%0b imm=%h op=%h exp v=1 rdy=0 imm=1234 op=0f",
                                   c, i0.out_valid, i0.in_ready, i0.zeroExtendedImmidiate, i0.opCode);
            end
            step();
        end
        i0.flush = 1;
        step();
        i0.flush = 0; i0.in_valid = 0;
        checks++; if (i0.out_valid !== 1'b0 || i0.zeroExtendedImmidiate !== 32'h1234) begin
            errors++; $display("FAIL flush got v=%0b imm=%h exp v=0 imm=1234", i0.out_valid, i0.zeroExtendedImmidiate);
        end
        i0.out_ready = 1;
        step();
        checks++; if (i0.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %0b exp 0", i0.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] imms [3];
        imms[0] = 16'h0011; imms[1] = 16'h0022; imms[2] = 16'h0033;
        i0.out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            i0.in_valid = 1; i0.instruction = {16'h2000, imms[k]};
            #1;
            checks++; if (i0.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %0b exp 1", k, i0.in_ready); end
            step();
            checks++; if (i0.out_valid !== 1'b1 || i0.zeroExtendedImmidiate !== {16'h0, imms[k]}) begin
                errors++; $display("FAIL b2b_out_%0d got v=%0b imm=%h exp v=1 imm=%h", k, i0.out_valid, i0.zeroExtendedImmidiate, imms[k]);
            end
        end
        i0.in_valid = 0;
        step();
    endtask

    task automatic test_zero_reg();
        i0.regWrite = 1; i0.writeReg = 5'd0;  i0.writeData = 32'h1234;
        i1.regWrite = 1; i1.writeReg = 5'd0;  i1.writeData = 32'h1234;
        i2.regWrite = 1; i2.writeReg = 5'd20; i2.writeData = 32'hABCD;
        step();
        i2.writeReg = 5'd15; i2.writeData = 32'h55;
        i0.regWrite = 0; i1.regWrite = 0;
        i0.in_valid = 1; i0.instruction = 32'h0000_0000;
        i1.in_valid = 1; i1.instruction = 32'h0000_0000;
        i2.in_valid = 1; i2.instruction = 32'h0280_0000;
        step();
        i2.regWrite = 0;
        checks++; if (i0.readData1 !== 32'h0) begin errors++; $display("FAIL zero_reg_r0 got %h exp 0", i0.readData1); end
        checks++; if (i1.readData1 !== 32'h1234) begin errors++; $display("FAIL nozero_r0 got %h exp 1234", i1.readData1); end
        checks++; if (i2.readData1 !== 32'h0 || i2.out_valid !== 1'b1) begin
            errors++; $display("FAIL regcnt16_r20 got d=%h v=%0b exp d=0 v=1", i2.readData1, i2.out_valid);
        end
        i2.instruction = 32'h01E0_0000;
        i0.in_valid = 0; i1.in_valid = 0;
        step();
        i2.in_valid = 0;
        checks++; if (i2.readData1 !== 32'h55) begin errors++; $display("FAIL regcnt16_r15 got %h exp 55", i2.readData1); end
    endtask

    task automatic test_mid_reset();
        i0.out_ready = 0; i0.in_valid = 1; i0.instruction = 32'h0060_0000;
        step();
        i0.in_valid = 0;
        checks++; if (i0.out_valid !== 1'b1 || i0.readData1 !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL pre_reset got v=%0b d=%h exp v=1 d=deadbeef", i0.out_valid, i0.readData1);
        end
        #2 rst_n = 0;
        #1;
        checks++; if (i0.out_valid !== 1'b0 || i0.readData1 !== 32'h0) begin
            errors++; $display("FAIL async_reset got v=%0b d=%h exp v=0 d=0", i0.out_valid, i0.readData1);
        end
        step();
        rst_n = 1; i0.out_ready = 1; i0.in_valid = 1;
        step();
        i0.in_valid = 0;
        checks++; if (i0.out_valid !== 1'b1 || i0.readData1 !== 32'h0) begin
            errors++; $display("FAIL regfile_cleared got v=%0b d=%h exp v=1 d=0", i0.out_valid, i0.readData1);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_immediates();
        test_load_use();
        test_backpressure_flush();
        test_back_to_back();
        test_zero_reg();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
